// File: rtl/prgm_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prgm_loader_pkg
//  Description : Shared op-codes, FSM state encoding and counter width for
//                the FPGAComputer programming-interface loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package prgm_loader_pkg;

  // Header byte op-codes (header = {op[7:4], sel[3:0]})
  localparam logic [3:0] c_OP_NOP     = 4'h0;
  localparam logic [3:0] c_OP_LOAD    = 4'h1;
  localparam logic [3:0] c_OP_OUTPUT  = 4'h2;
  localparam logic [3:0] c_OP_CAPTURE = 4'h3;
  localparam logic [3:0] c_OP_RUN     = 4'h4;
  localparam logic [3:0] c_OP_HALT    = 4'h5;
  localparam logic [3:0] c_OP_RESUME  = 4'h6;
  localparam logic [3:0] c_OP_MRESET  = 4'h7;
  localparam logic [3:0] c_OP_STOP    = 4'h8;

  // Width of the GO strobe-length counter (GO_CYCLES is 1..15)
  localparam int c_GO_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_RUN    = 3'd5
  } state_t;

  // Ops that go straight from the header to SETUP without a data byte
  function automatic logic is_direct_strobe_op(input logic [3:0] op);
    return (op == c_OP_OUTPUT) || (op == c_OP_CAPTURE) ||
           (op == c_OP_RUN)    || (op == c_OP_MRESET);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prgm_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prgm_loader_if
//  Description : Command stream handshake plus FPGAComputer programming
//                strobes. Readback signals exist only when
//                PRGM_LOADER_READBACK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prgm_loader_if;

  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [3:0] sel;
  logic [7:0] prgm_in;
  logic       go;
  logic       prgm;
  logic       oe;
  logic       we;
  logic       en;
  logic       hlt;
  logic       mrst;
  logic       busy;
  logic       err;

`ifdef PRGM_LOADER_READBACK_EN
  logic [7:0] bus_in;
  logic       rb_valid;
  logic [7:0] rb_data;

  modport master (
    output cmd_valid, cmd_data, bus_in,
    input  cmd_ready, sel, prgm_in, go, prgm, oe, we, en, hlt, mrst, busy, err,
           rb_valid, rb_data
  );

  modport slave (
    input  cmd_valid, cmd_data, bus_in,
    output cmd_ready, sel, prgm_in, go, prgm, oe, we, en, hlt, mrst, busy, err,
           rb_valid, rb_data
  );
`else
  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, sel, prgm_in, go, prgm, oe, we, en, hlt, mrst, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, sel, prgm_in, go, prgm, oe, we, en, hlt, mrst, busy, err
  );
`endif

endinterface
`default_nettype wire

// File: rtl/prgm_strobe_timer.sv
`default_nettype none
// ============================================================================
//  Module      : prgm_strobe_timer
//  Description : Loadable down-counter; o_done marks the final cycle of the
//                GO strobe so the FSM can leave STROBE on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module prgm_strobe_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load the strobe length in SETUP, then count down once per STROBE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A count of one means the current GO cycle is the last
  assign o_done = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/prgm_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prgm_loader
//  Description : Byte-command driven sequencer for the FPGAComputer
//                programming strobes (SEL/PRGM_IN/GO/PRGM/OE/WE/EN/HLT/MRST).
//                Optional readback of the module bus on OUTPUT is enabled by
//                defining PRGM_LOADER_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module prgm_loader
  import prgm_loader_pkg::*;
#(
  parameter int unsigned GO_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  prgm_loader_if.slave bus
);

  localparam logic [c_GO_CNT_W-1:0] c_GO_LOAD = c_GO_CNT_W'(GO_CYCLES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_op;
  logic [3:0] r_sel;
  logic [7:0] r_prgm_in;
  logic       r_hlt;
  logic       r_err;

  logic [3:0] w_hdr_op;
  logic       w_cmd_ready;
  logic       w_accept;
  logic       w_timer_load;
  logic       w_timer_dec;
  logic       w_timer_done;
  logic       w_active;
  logic       w_go;

  assign w_hdr_op    = bus.cmd_data[7:4];
  // Ready only in the byte-consuming states, and never while reset is held
  assign w_cmd_ready = !reset &&
                       ((r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_RUN));
  assign w_accept    = bus.cmd_valid && w_cmd_ready;

  prgm_strobe_timer #(
    .CNT_W (c_GO_CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_timer_load),
    .i_load_val (c_GO_LOAD),
    .i_dec      (w_timer_dec),
    .o_done     (w_timer_done)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus strobe-window and GO outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_load = 1'b0;
    w_timer_dec  = 1'b0;
    w_active     = 1'b0;
    w_go         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hdr_op == c_OP_LOAD) begin
            w_state_nxt = ST_DATA;
          end else if (is_direct_strobe_op(w_hdr_op)) begin
            w_state_nxt = ST_SETUP;
          end
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_active     = 1'b1;
        w_timer_load = 1'b1;
        w_state_nxt  = ST_STROBE;
      end
      ST_STROBE: begin
        w_active    = 1'b1;
        w_go        = 1'b1;
        w_timer_dec = 1'b1;
        if (w_timer_done) begin
          w_state_nxt = (r_op == c_OP_RUN) ? ST_RUN : ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_active    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        w_active = 1'b1;
        w_go     = 1'b1;
        if (w_accept && (w_hdr_op == c_OP_STOP)) begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command side effects: latch target/data, HLT level and sticky ERR
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= c_OP_NOP;
      r_sel     <= '0;
      r_prgm_in <= '0;
      r_hlt     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if ((w_hdr_op == c_OP_LOAD) || is_direct_strobe_op(w_hdr_op)) begin
              r_op  <= w_hdr_op;
              r_sel <= bus.cmd_data[3:0];
            end
            case (w_hdr_op)
              c_OP_NOP:    r_err <= 1'b0;
              c_OP_HALT:   r_hlt <= 1'b1;
              c_OP_RESUME: r_hlt <= 1'b0;
              c_OP_LOAD, c_OP_OUTPUT, c_OP_CAPTURE, c_OP_RUN, c_OP_MRESET: ;
              default:     r_err <= 1'b1;  // STOP outside RUN, or illegal op
            endcase
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_prgm_in <= bus.cmd_data;
          end
        end
        ST_RUN: begin
          if (w_accept && (w_hdr_op != c_OP_STOP)) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PRGM_LOADER_READBACK_EN
  logic       r_rb_valid;
  logic [7:0] r_rb_data;

  // Capture the bus on the last GO cycle of OUTPUT; valid pulses through HOLD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
    end else begin
      r_rb_valid <= 1'b0;
      if ((r_state == ST_STROBE) && w_timer_done && (r_op == c_OP_OUTPUT)) begin
        r_rb_valid <= 1'b1;
        r_rb_data  <= bus.bus_in;
      end
    end
  end

  assign bus.rb_valid = r_rb_valid;
  assign bus.rb_data  = r_rb_data;
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.sel       = r_sel;
  assign bus.prgm_in   = r_prgm_in;
  assign bus.go        = w_go;
  assign bus.prgm      = w_active && (r_op == c_OP_LOAD);
  assign bus.oe        = w_active && (r_op == c_OP_OUTPUT);
  assign bus.we        = w_active && (r_op == c_OP_CAPTURE);
  assign bus.en        = w_active && (r_op == c_OP_RUN);
  assign bus.mrst      = w_active && (r_op == c_OP_MRESET);
  assign bus.hlt       = r_hlt;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.err       = r_err;

endmodule
`default_nettype wire
